// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DEF_DVSR   = 54;

   // Total clk cycles of one frame: start + data bits at OVERSAMPLE ticks each, plus stop ticks.
   function automatic int unsigned frame_clks(input int unsigned dbit,
                                              input int unsigned sb_tick,
                                              input int unsigned dvsr);
      return (OVERSAMPLE * (1 + dbit) + sb_tick) * dvsr;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every DVSR clk cycles, with a synchronous
// clear so a frame can start on a fresh tick phase.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned DVSR = DEF_DVSR
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(DVSR);
   localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and frames them on tx
// (start bit, DBIT data bits LSB first, stop bit) using 16x baud ticks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned DVSR    = DEF_DVSR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_data,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [4:0]    S_LAST    = 5'(OVERSAMPLE - 1);
   localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   uart_state_t     state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            tick;
   logic            pop;
   logic            done;

   // Cleared on pop so every bit of the frame is exactly OVERSAMPLE*DVSR clk long.
   uart_baud_gen #(
      .DVSR(DVSR)
   ) u_baud_gen (
      .clk (clk),
      .rst (rst),
      .clr (pop),
      .tick(tick)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_data;
               s_d     = '0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  shreg_d = shreg_q >> 1;
                  s_d     = '0;
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_q == STOP_LAST) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // No pop or done pulse may escape while reset is held.
      if (rst) begin
         pop  = 1'b0;
         done = 1'b0;
      end

      // tx is registered from the next state so the line moves in step with the FSM.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   assign fifo_rd      = pop;
   assign tx           = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO models feed two instances (1 and 2 stop bits),
// a scoreboard holds the bytes expected on the line.
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // FIFO models: writes come from the stimulus tasks, pops from the DUT strobes.
   logic [7:0] mem16 [0:15];
   logic [7:0] mem32 [0:15];
   int         wr16 = 0, rd16 = 0, wr32 = 0, rd32 = 0;

   logic       fifo_empty16, fifo_rd16, tx16, busy16, done16;
   logic       fifo_empty32, fifo_rd32, tx32, busy32, done32;
   logic [7:0] fifo_data16, fifo_data32;

   assign fifo_empty16 = (wr16 == rd16);
   assign fifo_empty32 = (wr32 == rd32);
   assign fifo_data16  = mem16[rd16[3:0]];
   assign fifo_data32  = mem32[rd32[3:0]];

   always @(posedge clk) begin
      if (fifo_rd16) rd16 <= rd16 + 1;
      if (fifo_rd32) rd32 <= rd32 + 1;
   end

   uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut16 (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty16),
      .fifo_data   (fifo_data16),
      .fifo_rd     (fifo_rd16),
      .tx          (tx16),
      .tx_busy     (busy16),
      .tx_done_tick(done16)
   );

   uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(4)) dut32 (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty32),
      .fifo_data   (fifo_data32),
      .fifo_rd     (fifo_rd32),
      .tx          (tx32),
      .tx_busy     (busy32),
      .tx_done_tick(done32)
   );

   logic sel = 1'b0;
   logic tx_m, rd_m, busy_m, done_m;
   assign tx_m   = sel ? tx32   : tx16;
   assign rd_m   = sel ? fifo_rd32 : fifo_rd16;
   assign busy_m = sel ? busy32 : busy16;
   assign done_m = sel ? done32 : done16;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp16 [$];
   logic [7:0] exp32 [$];

   logic tx_s   [0:1299];
   logic rd_s   [0:1299];
   logic busy_s [0:1299];
   logic done_s [0:1299];

   task automatic push16(input logic [7:0] b);
      mem16[wr16[3:0]] = b;
      wr16 = wr16 + 1;
      exp16.push_back(b);
   endtask

   task automatic push32(input logic [7:0] b);
      mem32[wr32[3:0]] = b;
      wr32 = wr32 + 1;
      exp32.push_back(b);
   endtask

   // Leaves the bench 1 time unit into the pop cycle N.
   task automatic wait_pop(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (rd_m === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Sample k = 1..len is taken mid-cycle in cycle N+k.
   task automatic capture(input int len);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         tx_s[k]   = tx_m;
         rd_s[k]   = rd_m;
         busy_s[k] = busy_m;
         done_s[k] = done_m;
      end
   endtask

   function automatic int tx_mism(input int lo, input int hi, input logic v);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (tx_s[k] !== v) c++;
      return c;
   endfunction

   // Data bit i of a frame popped at base occupies base+65+64i .. base+128+64i.
   function automatic int data_mism(input int base, input logic [7:0] b);
      int c = 0;
      for (int i = 0; i < 8; i++)
         for (int k = base + 65 + 64 * i; k <= base + 128 + 64 * i; k++)
            if (tx_s[k] !== b[i]) c++;
      return c;
   endfunction

   function automatic int done_mism(input int hi, input int p1, input int p2);
      int c = 0;
      for (int k = 1; k <= hi; k++) if (done_s[k] !== ((k == p1) || (k == p2))) c++;
      return c;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      push16(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx16 !== 1'b1) begin
            errors++; $display("FAIL reset_tx cycle %0d: got %b want 1", i, tx16);
         end
         checks++;
         if (fifo_rd16 !== 1'b0) begin
            errors++; $display("FAIL reset_fifo_rd cycle %0d: got %b want 0", i, fifo_rd16);
         end
         checks++;
         if (busy16 !== 1'b0) begin
            errors++; $display("FAIL reset_busy cycle %0d: got %b want 0", i, busy16);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      bit ok;
      logic [7:0] e;
      int m;
      sel = 1'b0;
      wait_pop(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL single_pop: got no fifo_rd want pop within 50 clk");
      end
      capture(641);
      checks++;
      if (exp16.size() == 0) begin
         errors++; $display("FAIL single_scoreboard: got empty want one byte");
         e = 8'h00;
      end else e = exp16.pop_front();
      m = tx_mism(1, 64, 1'b0);
      checks++;
      if (m != 0) begin errors++; $display("FAIL single_start: got %0d bad samples want 0", m); end
      m = data_mism(0, e);
      checks++;
      if (m != 0) begin
         errors++; $display("FAIL single_data: got %0d bad samples want 0 (byte %h)", m, e);
      end
      m = tx_mism(577, 640, 1'b1);
      checks++;
      if (m != 0) begin errors++; $display("FAIL single_stop: got %0d bad samples want 0", m); end
      m = done_mism(641, 640, 640);
      checks++;
      if (m != 0) begin errors++; $display("FAIL single_done: got %0d bad samples want 0", m); end
      checks++;
      if (busy_s[1] !== 1'b1 || busy_s[641] !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: got %b/%b want 1/0", busy_s[1], busy_s[641]);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      logic [7:0] e1, e2;
      int m, rd0, extra;
      sel = 1'b0;
      push16(8'h00);
      push16(8'hFF);
      rd0 = rd16;
      wait_pop(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_pop: got no fifo_rd want pop"); end
      capture(1290);
      e1 = (exp16.size() > 0) ? exp16.pop_front() : 8'h55;
      e2 = (exp16.size() > 0) ? exp16.pop_front() : 8'h55;
      m = tx_mism(1, 64, 1'b0) + data_mism(0, e1) + tx_mism(577, 641, 1'b1);
      checks++;
      if (m != 0) begin errors++; $display("FAIL b2b_frame1: got %0d bad samples want 0", m); end
      checks++;
      if (rd_s[641] !== 1'b1) begin
         errors++; $display("FAIL b2b_second_pop: got %b at N+641 want 1", rd_s[641]);
      end
      checks++;
      if (tx_s[642] !== 1'b0) begin
         errors++; $display("FAIL b2b_second_start: got %b at N+642 want 0", tx_s[642]);
      end
      m = tx_mism(642, 705, 1'b0) + data_mism(641, e2) + tx_mism(1218, 1290, 1'b1);
      checks++;
      if (m != 0) begin errors++; $display("FAIL b2b_frame2: got %0d bad samples want 0", m); end
      m = done_mism(1290, 640, 1281);
      checks++;
      if (m != 0) begin errors++; $display("FAIL b2b_done: got %0d bad samples want 0", m); end
      extra = 0;
      for (int k = 1; k <= 1290; k++) if (k != 641 && rd_s[k] !== 1'b0) extra++;
      checks++;
      if (extra != 0 || rd16 - rd0 != 2) begin
         errors++; $display("FAIL b2b_pops: got %0d pops (%0d stray) want 2", rd16 - rd0, extra);
      end
   endtask

   task automatic test_empty;
      int rds = 0, lows = 0, dones = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (fifo_rd16 !== 1'b0) rds++;
         if (tx16 !== 1'b1) lows++;
         if (done16 !== 1'b0) dones++;
      end
      checks++;
      if (rds != 0) begin errors++; $display("FAIL empty_rd: got %0d strobes want 0", rds); end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL empty_tx: got %0d non-high want 0", lows); end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL empty_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int rd0, rds, lows;
      logic [7:0] b;
      sel = 1'b0;
      b = 8'h3C;
      push16(b);
      void'(exp16.pop_front()); // aborted frame, never appears on the line
      rd0 = rd16;
      wait_pop(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_pop: got no fifo_rd want pop"); end
      for (int k = 1; k <= 300; k++) @(negedge clk);
      checks++;
      if (tx16 !== b[3] || busy16 !== 1'b1) begin
         errors++; $display("FAIL rstmid_before: got tx %b busy %b want %b 1", tx16, busy16, b[3]);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tx16 !== 1'b1 || busy16 !== 1'b0) begin
         errors++; $display("FAIL rstmid_after: got tx %b busy %b want 1 0", tx16, busy16);
      end
      rst = 1'b0;
      rds = 0; lows = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (fifo_rd16 !== 1'b0) rds++;
         if (tx16 !== 1'b1) lows++;
      end
      checks++;
      if (rds != 0 || rd16 - rd0 != 1) begin
         errors++; $display("FAIL rstmid_pops: got %0d pops %0d strobes want 1 0", rd16 - rd0, rds);
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL rstmid_idle_tx: got %0d low want 0", lows); end
   endtask

   task automatic test_two_stop;
      bit ok;
      logic [7:0] e;
      int m;
      sel = 1'b1;
      push32(8'h81);
      wait_pop(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sb32_pop: got no fifo_rd want pop"); end
      capture(710);
      e = (exp32.size() > 0) ? exp32.pop_front() : 8'h55;
      m = tx_mism(1, 64, 1'b0) + data_mism(0, e);
      checks++;
      if (m != 0) begin errors++; $display("FAIL sb32_data: got %0d bad samples want 0", m); end
      m = tx_mism(577, 710, 1'b1);
      checks++;
      if (m != 0) begin errors++; $display("FAIL sb32_stop: got %0d bad samples want 0", m); end
      m = done_mism(710, 704, 704);
      checks++;
      if (m != 0) begin errors++; $display("FAIL sb32_done: got %0d bad samples want 0", m); end
      checks++;
      if (busy_s[704] !== 1'b1 || busy_s[705] !== 1'b0) begin
         errors++;
         $display("FAIL sb32_busy: got %b/%b want 1/0", busy_s[704], busy_s[705]);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_empty();
      test_reset_mid();
      test_two_stop();
      checks++;
      if (exp16.size() != 0 || exp32.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp16.size(), exp32.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
